// File: rtl/aes_ctrl_pkg.sv
// Shared constants for the iterative AES-128 control path: state encoding,
// round count and round-index width.
package aes_ctrl_pkg;

  localparam int AES_NR = 10;
  localparam int AES_RW = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_INIT  = 4'd2,
    S_ROUND = 4'd3,
    S_FINAL = 4'd4,
    S_DONE  = 4'd5
  } state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Loadable up/down round-key index counter with preset to 0 / NR and
// detection of the last full round in either direction.
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int RW = AES_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          preset,
  input  logic          step,
  input  logic          down,
  output logic [RW-1:0] count,
  output logic          terminal
);

  localparam logic [RW-1:0] NR_V  = RW'(NR);
  localparam logic [RW-1:0] NR_M1 = RW'(NR - 1);
  localparam logic [RW-1:0] ONE   = RW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (preset) begin
      count <= down ? NR_V : '0;
    end else if (step) begin
      count <= down ? count - ONE : count + ONE;
    end
  end

  // Terminal marks the last full round; the step taken on it lands on NR or 0.
  assign terminal = down ? (count == ONE) : (count == NR_M1);

  assert property (@(posedge clk) disable iff (rst) count <= NR_V);

endmodule

// File: rtl/aes_round_sequencer.sv
// Moore control FSM for the iterative AES-128 datapath: load, initial
// AddRoundKey, NR-1 full rounds, final round, then a held Done handshake.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int RW = AES_RW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Select,
  input  logic          Out_Ack,
  output logic          Load,
  output logic          Init_Ark,
  output logic          Round_En,
  output logic          Final_En,
  output logic          Inv,
  output logic [RW-1:0] Round,
  output logic          Busy,
  output logic          Done
);

  state_t        state;
  state_t        state_nxt;
  logic          inv;
  logic          cnt_clear;
  logic          cnt_preset;
  logic          cnt_step;
  logic          cnt_terminal;
  logic [RW-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Direction is captured only when a job is accepted, so Select may move freely afterwards.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inv <= 1'b0;
    end else if (state == S_IDLE && Start) begin
      inv <= Select;
    end
  end

  always_comb begin
    state_nxt  = S_IDLE;
    cnt_clear  = 1'b0;
    cnt_preset = 1'b0;
    cnt_step   = 1'b0;
    case (state)
      S_IDLE:  state_nxt = Start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        cnt_preset = 1'b1;
        state_nxt  = S_INIT;
      end
      S_INIT: begin
        cnt_step  = 1'b1;
        state_nxt = S_ROUND;
      end
      S_ROUND: begin
        cnt_step  = 1'b1;
        state_nxt = cnt_terminal ? S_FINAL : S_ROUND;
      end
      S_FINAL: state_nxt = S_DONE;
      S_DONE: begin
        if (Out_Ack) begin
          cnt_clear = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        cnt_clear = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  aes_round_counter #(
    .NR(NR),
    .RW(RW)
  ) u_counter (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (cnt_clear),
    .preset  (cnt_preset),
    .step    (cnt_step),
    .down    (inv),
    .count   (cnt),
    .terminal(cnt_terminal)
  );

  assign Load     = (state == S_LOAD);
  assign Init_Ark = (state == S_INIT);
  assign Round_En = (state == S_ROUND);
  assign Final_En = (state == S_FINAL);
  assign Done     = (state == S_DONE);
  assign Busy     = Load | Init_Ark | Round_En | Final_En;
  assign Inv      = inv;
  assign Round    = cnt;

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Registered control sequencer for the iterative AES-128 datapath. It accepts an encrypt/decrypt request and steps the datapath through load, initial AddRoundKey, NR-1 full rounds and the final round. It drives a round-key index and holds a done/acknowledge handshake toward the consumer. It replaces the ad-hoc external state register and round counter with one self-contained block.

Parameters:
NR, 10, number of cipher rounds (AES-128)
RW, 4, width of the round index and counter; must satisfy 2^RW > NR

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only in IDLE
Select  input  1  0 = encrypt, 1 = decrypt; sampled with Start
Out_Ack  input  1  consumer has taken the result; sampled only in DONE
Load  output  1  load plaintext/ciphertext into the state register
Init_Ark  output  1  perform the initial AddRoundKey
Round_En  output  1  perform one full round (with Mix/InvMixColumns)
Final_En  output  1  perform the final round (no MixColumns)
Inv  output  1  latched Select; datapath uses inverse transforms when 1
Round  output  RW  round-key index for the key schedule
Busy  output  1  high in every state except IDLE and DONE
Done  output  1  result valid; held until acknowledged

Behaviour:
- One clock; reset is asynchronous and active-high.
- States: IDLE, LOAD, INIT, ROUND, FINAL, DONE. The state register and round counter are reset asynchronously.
- All outputs are Moore outputs, decoded from registered state, counter and Inv. No input reaches an output combinationally.
- Reset values: state IDLE, Round 0, Inv 0, and all other outputs 0. Reset asserted mid-operation aborts immediately to these values. No partial result is flagged.
- IDLE: if Start=1 at the edge, go to LOAD and latch Inv<=Select. Otherwise stay in IDLE. Round=0.
- LOAD: Load=1. Go to INIT. Round is preset to 0 (encrypt) or NR (decrypt).
- INIT: Init_Ark=1. Round=0 (encrypt) or NR (decrypt). Next, the counter steps toward the first full round (+1 for encrypt, -1 for decrypt) and the state goes to ROUND.
- ROUND: Round_En=1 for exactly NR-1 cycles. Round takes the values 1..NR-1 (encrypt) or NR-1..1 (decrypt), stepping by one each cycle.
  - Leave ROUND when Round is NR-1 (encrypt) or 1 (decrypt). The counter steps once more, to NR or 0 respectively, and the state goes to FINAL.
- FINAL: Final_En=1. Round=NR (encrypt) or 0 (decrypt). Go to DONE.
- DONE: Done=1 and Round holds. If Out_Ack=1, go to IDLE and reset Round to 0. Otherwise stay in DONE indefinitely.
- Latency: Start sampled at edge k gives LOAD after k, INIT after k+1, ROUND after k+2 through k+NR, FINAL after k+NR+1, and DONE after k+NR+2 (edge k+12 for NR=10).
- Exactly one of Load/Init_Ark/Round_En/Final_En/Done is high in non-IDLE states; all are 0 in IDLE.
- Start while Busy or in DONE is ignored and not queued.
- Select changes after the Start sample are ignored. Inv stays stable from LOAD until the next accepted Start.
- Start=1 and Out_Ack=1 together in DONE: go to IDLE only. The new Start must be held or re-asserted in IDLE; at least one IDLE cycle separates jobs.
- Out_Ack outside DONE is ignored.
- Unused state encodings recover to IDLE on the next edge.
- The counter never wraps. Reaching a value outside 0..NR is unreachable and is a verification assertion.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - the state encoding constants (4-bit: IDLE=0, LOAD=1, INIT=2, ROUND=3, FINAL=4, DONE=5);
  - the AES-128 NR constant;
  - the round-index width.
- One sub-module, aes_round_counter: a loadable up/down RW-bit counter with preset-to-0/NR and a terminal-detect output (at NR-1 going up, at 1 going down). The sequencer FSM instantiates it.

Test Plan:
- Encrypt: Reset, then Start=1 and Select=0 for one cycle. Required: Load at +1; Init_Ark with Round=0 at +2; Round_En with Round=1..9 at +3..+11; Final_En with Round=10 at +12; Done=1 from +13 until Out_Ack; Inv=0 throughout.
- Decrypt: Start=1, Select=1. Required: Init_Ark with Round=10; Round_En with Round=9..1; Final_En with Round=0; Done at +13; Inv=1 throughout.
- Start held high continuously, Out_Ack pulsed 5 cycles after Done. Required: Done stays high those 5 cycles; IDLE for one cycle; second job's Load exactly 2 cycles after the Out_Ack edge. No Start is accepted during Busy.
- Select toggled every cycle during an encrypt job. Required: Inv stays 0 and the Round sequence is unchanged.
- Reset asserted asynchronously (mid-cycle) while Round=5 in ROUND. Required: all outputs 0 immediately and state IDLE. After release, a new Start gives a normal 13-cycle job.
- In DONE, Start=1 and Out_Ack=1 on the same edge. Required: next state IDLE with Load=0. With Start still high, LOAD is entered on the following edge.
